// File: rtl/dbg_pkg.sv
// Shared opcodes, widths and FSM encoding for the debug step controller.
package dbg_pkg;

    localparam int PC_W   = 32;
    localparam int RF_AW  = 5;
    localparam int STEP_W = 16;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    localparam logic [RF_AW-1:0] LAST_IDX = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STEP     = 3'd2,
        ST_DUMP_RD  = 3'd3,
        ST_DUMP_OUT = 3'd4
    } state_t;

endpackage

// File: rtl/dbg_bp_match.sv
// Breakpoint comparator: flags when the CPU PC equals the armed breakpoint address.
module dbg_bp_match
    import dbg_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] bp_addr,
    input  logic            bp_en,
    output logic            match
);

    assign match = bp_en && (pc == bp_addr);

endmodule

// File: rtl/dbg_step_ctrl.sv
// Debug controller for a MIPS core: run/halt, N-cycle step, breakpoint stop
// and a 32-word register-file dump streamed over a valid/ready port.
//
// state       | meaning
// ST_IDLE     | halted, accepting commands
// ST_RUN      | free-running until HALT or breakpoint
// ST_STEP     | cpu_en held high while the step counter runs down
// ST_DUMP_RD  | one cycle to latch rf_data for the current index
// ST_DUMP_OUT | presenting a captured word, waiting for dump_ready
module dbg_step_ctrl
    import dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc_current,
    output logic              cpu_en,
    output logic [RF_AW-1:0]  rf_addr,
    input  logic [31:0]       rf_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [RF_AW-1:0]  dump_idx,
    output logic [31:0]       dump_data,
    output logic              bp_hit,
    output logic [31:0]       cyc_count
);

    state_t              state_q, state_d;
    logic                first_q, first_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [RF_AW-1:0]    rf_addr_q, rf_addr_d;
    logic [RF_AW-1:0]    dump_idx_q, dump_idx_d;
    logic [31:0]         dump_data_q, dump_data_d;
    logic                dump_valid_q, dump_valid_d;
    logic                bp_hit_q, bp_hit_d;
    logic [31:0]         cyc_q, cyc_d;
    logic                bp_match;
    logic                cmd_fire;
    logic                bp_stop;

    dbg_bp_match u_bp_match (
        .pc      (pc_current),
        .bp_addr (bp_addr),
        .bp_en   (bp_en),
        .match   (bp_match)
    );

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign cmd_fire  = cmd_valid && cmd_ready;
    // The first RUN cycle always advances so a resume from the breakpoint PC makes progress.
    assign bp_stop   = bp_match && !first_q;

    always_comb begin
        state_d      = state_q;
        first_d      = 1'b0;
        cnt_d        = cnt_q;
        rf_addr_d    = rf_addr_q;
        dump_idx_d   = dump_idx_q;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;
        bp_hit_d     = bp_hit_q;
        cpu_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_d  = ST_RUN;
                            first_d  = 1'b1;
                            bp_hit_d = 1'b0;
                        end
                        OP_STEP: begin
                            if (cmd_arg != '0) begin
                                state_d = ST_STEP;
                                cnt_d   = cmd_arg;
                            end
                        end
                        OP_DUMP: begin
                            state_d   = ST_DUMP_RD;
                            rf_addr_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cpu_en = !bp_stop;
                if (bp_stop) begin
                    bp_hit_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cmd_fire && (cmd_op == OP_HALT)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                cpu_en = 1'b1;
                cnt_d  = cnt_q - STEP_W'(1);
                if (cnt_q == STEP_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DUMP_RD: begin
                dump_data_d  = rf_data;
                dump_idx_d   = rf_addr_q;
                dump_valid_d = 1'b1;
                state_d      = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (rf_addr_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        rf_addr_d = rf_addr_q + RF_AW'(1);
                        state_d   = ST_DUMP_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cyc_d = cpu_en ? (cyc_q + 32'd1) : cyc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            first_q      <= 1'b0;
            cnt_q        <= '0;
            rf_addr_q    <= '0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            bp_hit_q     <= 1'b0;
            cyc_q        <= '0;
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            cnt_q        <= cnt_d;
            rf_addr_q    <= rf_addr_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            bp_hit_q     <= bp_hit_d;
            cyc_q        <= cyc_d;
        end
    end

    assign rf_addr    = rf_addr_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign dump_valid = dump_valid_q;
    assign bp_hit     = bp_hit_q;
    assign cyc_count  = cyc_q;

endmodule
